// File: rtl/mem_access_unit.sv
// Purpose: single-port word memory with byte/half/word loads and stores and a one-entry response stage.
// Latency: a response is presented one cycle after the request is accepted.
// Backpressure: a held response (resp_ready low) drops req_ready until it is consumed; full rate otherwise.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/req_wdata : request channel
//   resp_valid/resp_ready/resp_rdata/resp_err                           : response channel
module mem_access_unit #(
  parameter int ADDR_W    = 8,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, RESP} state_t;

  state_t state_q, state_d;

  // Memory is deliberately left out of reset; contents survive reset pulses.
  logic [31:0] mem [DEPTH] = '{default: (INIT_ZERO ? 32'h0 : 32'hx)};

  logic              accept;
  logic              req_err;
  logic              addr_hi_err;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_rep;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic [31:0]       load_ext;
  logic [31:0]       rdata_q;
  logic              err_q;

  assign accept   = req_valid && req_ready;
  assign word_idx = req_addr[ADDR_W+1:2];
  assign lane     = req_addr[1:0];
  assign rd_word  = mem[word_idx];
  // Bytes beyond the implemented depth are out of range.
  assign addr_hi_err = (req_addr >> (ADDR_W + 2)) != 32'd0;

  // Legality, lane enables and replicated store data.
  always_comb begin
    req_err   = addr_hi_err;
    byte_en   = 4'b0000;
    wdata_rep = req_wdata;
    case (req_size)
      2'b00: begin
        byte_en   = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        if (lane[0]) req_err = 1'b1;
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        if (lane != 2'b00) req_err = 1'b1;
        byte_en   = 4'b1111;
      end
      default: req_err = 1'b1;
    endcase
  end

  // Load extraction: shift the selected lane down, then extend. A legal half
  // always has lane[0]=0, so the byte shift also serves halves.
  always_comb begin
    rd_shift = rd_word >> {lane, 3'b000};
    case (req_size)
      2'b00:   load_ext = req_unsigned ? {24'h0, rd_shift[7:0]}
                                       : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_ext = req_unsigned ? {16'h0, rd_shift[15:0]}
                                       : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: load_ext = rd_word;
    endcase
  end

  // Store path; gated by reset so no write lands while reset is held.
  always_ff @(posedge clk) begin
    if (reset && accept && req_we && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][b*8 +: 8] <= wdata_rep[b*8 +: 8];
      end
    end
  end

  // Response payload is captured at accept and held until the next accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (accept) begin
      err_q   <= req_err;
      rdata_q <= (req_err || req_we) ? 32'h0 : load_ext;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RESP;
      RESP:    if (resp_ready) state_d = accept ? RESP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    resp_valid = (state_q == RESP);
    req_ready  = (state_q == IDLE) || resp_ready;
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores/loads of each size, error
// requests, response backpressure, streaming, and reset mid-response.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int tests = 0;
  int fails = 0;

  mem_access_unit #(.ADDR_W(8), .INIT_ZERO(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  // Drive a request now, let the next rising edge accept it, and return 1ns
  // after that edge with req_valid dropped and the response visible.
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    resp_ready   = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", resp_valid); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    tests++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h exp 0", resp_rdata); end
    tests++; if (resp_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", resp_err); end
  endtask

  task automatic test_word();
    // Release reset at a falling edge and request at once: accepted on the
    // very first rising edge with reset high.
    @(negedge clk);
    reset = 1'b1;
    send(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    tests++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      fails++; $display("FAIL store_word_resp got v=%b e=%b d=%h exp v=1 e=0 d=0", resp_valid, resp_err, resp_rdata); end
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    tests++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL load_word got v=%b e=%b d=%h exp v=1 e=0 d=deadbeef", resp_valid, resp_err, resp_rdata); end
  endtask

  task automatic test_sub_word();
    send(1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFFFF80);
    tests++; if (resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      fails++; $display("FAIL store_byte got e=%b d=%h exp e=0 d=0", resp_err, resp_rdata); end
    send(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    tests++; if (resp_rdata !== 32'hFFFFFF80) begin fails++; $display("FAIL load_byte_s got %h exp ffffff80", resp_rdata); end
    send(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    tests++; if (resp_rdata !== 32'h00000080) begin fails++; $display("FAIL load_byte_u got %h exp 00000080", resp_rdata); end
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    tests++; if (resp_rdata !== 32'h80ADBEEF) begin fails++; $display("FAIL load_word_after_byte got %h exp 80adbeef", resp_rdata); end
    send(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    tests++; if (resp_rdata !== 32'hFFFF80AD) begin fails++; $display("FAIL load_half_s got %h exp ffff80ad", resp_rdata); end
    send(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    tests++; if (resp_rdata !== 32'h0000BEEF) begin fails++; $display("FAIL load_half_u got %h exp 0000beef", resp_rdata); end
    send(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    tests++; if (resp_rdata !== 32'hFFFFFFBE) begin fails++; $display("FAIL load_byte1_s got %h exp ffffffbe", resp_rdata); end
    // Half store into upper lanes of a zero word, then load it back next cycle.
    send(1'b1, 2'b01, 1'b0, 32'h16, 32'hAAAA1234);
    send(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    tests++; if (resp_rdata !== 32'h12340000) begin fails++; $display("FAIL store_half_lanes got %h exp 12340000", resp_rdata); end
  endtask

  task automatic test_errors();
    send(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
    tests++; if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
      fails++; $display("FAIL err_half_misalign got e=%b d=%h exp e=1 d=0", resp_err, resp_rdata); end
    send(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    tests++; if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
      fails++; $display("FAIL err_word_misalign got e=%b d=%h exp e=1 d=0", resp_err, resp_rdata); end
    send(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    tests++; if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
      fails++; $display("FAIL err_size11 got e=%b d=%h exp e=1 d=0", resp_err, resp_rdata); end
    send(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    tests++; if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
      fails++; $display("FAIL err_range_load got e=%b d=%h exp e=1 d=0", resp_err, resp_rdata); end
    // Rejected stores must leave memory untouched.
    send(1'b1, 2'b10, 1'b0, 32'h400, 32'h11111111);
    tests++; if (resp_err !== 1'b1) begin fails++; $display("FAIL err_range_store got e=%b exp 1", resp_err); end
    send(1'b1, 2'b10, 1'b0, 32'h12, 32'h22222222);
    send(1'b1, 2'b01, 1'b0, 32'h11, 32'h3333);
    send(1'b1, 2'b11, 1'b0, 32'h10, 32'h44444444);
    send(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    tests++; if (resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      fails++; $display("FAIL err_no_alias_write got e=%b d=%h exp e=0 d=0", resp_err, resp_rdata); end
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    tests++; if (resp_rdata !== 32'h80ADBEEF) begin fails++; $display("FAIL err_mem_unchanged got %h exp 80adbeef", resp_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    logic [1:0]  sizes [4];
    logic [31:0] exp_d [4];
    addrs = '{32'h10, 32'h14, 32'h13, 32'h0};
    sizes = '{2'b10, 2'b10, 2'b00, 2'b10};
    exp_d = '{32'h80ADBEEF, 32'h12340000, 32'h00000080, 32'h0};
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    // Stall the response with a new request pending.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h14;
    #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL stall_ready got %b exp 0", req_ready); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h80ADBEEF || resp_err !== 1'b0 || req_ready !== 1'b0) begin
        fails++; $display("FAIL stall_hold cyc %0d got v=%b d=%h e=%b rdy=%b exp v=1 d=80adbeef e=0 rdy=0",
                          c, resp_valid, resp_rdata, resp_err, req_ready); end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h12340000) begin
      fails++; $display("FAIL stall_release got v=%b d=%h exp v=1 d=12340000", resp_valid, resp_rdata); end
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_size = sizes[i]; req_unsigned = 1'b1; req_addr = addrs[i];
      @(posedge clk);
      #1;
      tests++; if (resp_valid !== 1'b1 || resp_rdata !== exp_d[i]) begin
        fails++; $display("FAIL stream %0d got v=%b d=%h exp v=1 d=%h", i, resp_valid, resp_rdata, exp_d[i]); end
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL stream_drain got v=%b exp 0", resp_valid); end
  endtask

  task automatic test_reset_mid();
    send(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
    send(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL pre_reset_load got v=%b d=%h exp v=1 d=deadbeef", resp_valid, resp_rdata); end
    // Hold a store request across the reset edge; it must not write.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'h0;
    resp_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    tests++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      fails++; $display("FAIL mid_reset got v=%b rdy=%b d=%h e=%b exp v=0 rdy=1 d=0 e=0",
                        resp_valid, req_ready, resp_rdata, resp_err); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
    send(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL post_reset_mem got v=%b d=%h exp v=1 d=deadbeef", resp_valid, resp_rdata); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_sub_word();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
